// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between a core front end and pc_sequencer.
// Ports (signals):
//   stall, br_take, jmp, jmp_reg  - control requests into the sequencer
//   imm, tgt, reg_addr            - target operands (word offsets / absolute address)
//   pc, pc_plus4                  - current fetch address and its sequential successor
//   redirect, addr_err            - registered status pulses
// Modports: master drives requests, slave (the sequencer) drives pc/status.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int TGT_W  = 26
);
    logic              stall;
    logic              br_take;
    logic              jmp;
    logic              jmp_reg;
    logic [IMM_W-1:0]  imm;
    logic [TGT_W-1:0]  tgt;
    logic [ADDR_W-1:0] reg_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic              addr_err;
    modport master (
        output stall, br_take, jmp, jmp_reg, imm, tgt, reg_addr,
        input  pc, pc_plus4, redirect, addr_err
    );
    modport slave (
        input  stall, br_take, jmp, jmp_reg, imm, tgt, reg_addr,
        output pc, pc_plus4, redirect, addr_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump/register-jump redirection and a one-entry pending target.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (pc <= RESET_VEC, pending dropped)
//   bus  - pc_sequencer_if.slave: requests in, pc/pc_plus4/redirect/addr_err out
// Optional feature: define PC_SEQUENCER_DELAY_SLOT_EN to execute one delay-slot
// instruction (pc+4) before every taken redirect.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                IMM_W     = 16,
    parameter int                TGT_W     = 26,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic             clk,
    input logic             rst,
    pc_sequencer_if.slave   bus
);
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
    // S_PEND: target held, delay slot not yet executed; S_SLOT: slot done, target due
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_SLOT} state_t;
`else
    typedef enum logic {S_IDLE, S_PEND} state_t;
`endif
    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_pc, r_tgt;
    logic              r_redirect, r_addr_err;
    logic [ADDR_W-1:0] w_pc_plus4, w_imm_ext, w_br_tgt, w_jmp_tgt, w_reg_tgt, w_req_tgt;
    logic [ADDR_W-1:0] w_next_pc, w_next_tgt;
    logic              w_req, w_has, w_redirect, w_addr_err;
    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_imm_ext  = ADDR_W'($signed(bus.imm));
    assign w_br_tgt   = w_pc_plus4 + (w_imm_ext << 2);
    assign w_jmp_tgt  = {w_pc_plus4[ADDR_W-1:TGT_W+2], bus.tgt, 2'b00};
    assign w_reg_tgt  = {bus.reg_addr[ADDR_W-1:2], 2'b00};
    assign w_req      = bus.jmp_reg | bus.jmp | bus.br_take;
    assign w_req_tgt  = bus.jmp_reg ? w_reg_tgt : bus.jmp ? w_jmp_tgt : w_br_tgt;
    // addr_err reports on sampling, independent of stall
    assign w_addr_err = bus.jmp_reg && (bus.reg_addr[1:0] != 2'b00);
    // newest request always replaces the held target
    assign w_next_tgt = w_req ? w_req_tgt : r_tgt;
    assign w_has      = w_req || (r_state != S_IDLE);
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_redirect   = 1'b0;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        if (!bus.stall) begin
            w_next_pc = w_pc_plus4;
            if (r_state == S_SLOT) begin
                w_next_pc    = w_next_tgt;
                w_redirect   = 1'b1;
                w_next_state = S_IDLE;
            end else if (w_has) begin
                w_next_state = S_SLOT;
            end
        end else if (r_state == S_IDLE && w_req) begin
            w_next_state = S_PEND;
        end
`else
        if (!bus.stall) begin
            w_next_pc    = w_has ? w_next_tgt : w_pc_plus4;
            w_redirect   = w_has;
            w_next_state = S_IDLE;
        end else if (w_req) begin
            w_next_state = S_PEND;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_VEC;
            r_tgt      <= '0;
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_tgt      <= w_next_tgt;
            r_redirect <= w_redirect;
            r_addr_err <= w_addr_err;
        end
    end
    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = w_pc_plus4;
    assign bus.redirect = r_redirect;
    assign bus.addr_err = r_addr_err;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and all address ports; legal range 30..64.
REQ-002 Parameter IMM_W, default 16, width of branch offset field.
REQ-003 Parameter TGT_W, default 26, width of jump target field; TGT_W+2 < ADDR_W.
REQ-004 Parameter RESET_VEC, default 0, PC value loaded on reset; bits [1:0] zero.
REQ-005 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port stall  in  1  hold PC; no sequential advance this cycle.
REQ-008 Port br_take  in  1  conditional branch resolved taken.
REQ-009 Port jmp  in  1  absolute jump request (J/JAL).
REQ-010 Port jmp_reg  in  1  register-indirect jump request (JR/JALR).
REQ-011 Port imm  in  IMM_W  branch offset, word units, two's complement.
REQ-012 Port tgt  in  TGT_W  jump target field, word units.
REQ-013 Port reg_addr  in  ADDR_W  register jump address.
REQ-014 Port pc  out  ADDR_W  current fetch address (registered).
REQ-015 Port pc_plus4  out  ADDR_W  pc+4, combinational from pc.
REQ-016 Port redirect  out  1  registered pulse: pc loaded from non-sequential target this cycle.
REQ-017 Port addr_err  out  1  registered pulse: misaligned reg_addr accepted.

Function
REQ-018 Branch target SHALL be pc_plus4 + (sign-extend(imm) to ADDR_W, shifted left 2), modulo 2^ADDR_W.
REQ-019 Jump target SHALL be {pc_plus4[ADDR_W-1:TGT_W+2], tgt, 2'b00}.
REQ-020 Register target SHALL be {reg_addr[ADDR_W-1:2], 2'b00}; addr_err SHALL pulse the cycle after acceptance when reg_addr[1:0] != 0.
REQ-021 Request priority SHALL be jmp_reg > jmp > br_take; lower requests in the same cycle are dropped.
REQ-022 Target SHALL be computed from pc/inputs in the cycle the request is sampled, regardless of stall.
REQ-023 Request with stall=0 SHALL load target into pc at next edge; redirect=1 for that one cycle.
REQ-024 Request with stall=1 SHALL be latched into a one-entry pending register; pc holds.
REQ-025 A new request while pending SHALL overwrite pending target (newest wins).
REQ-026 First edge with stall=0 and pending valid and no new request SHALL load pending target, clear pending, pulse redirect.
REQ-027 No request, no pending, stall=0: pc SHALL advance to pc_plus4 (wraps at 2^ADDR_W).
REQ-028 stall=1 with no request: pc, pending, redirect=0, addr_err=0 all hold/idle.

Reset
REQ-029 rst=1 at an edge SHALL set pc=RESET_VEC, pending cleared, redirect=0, addr_err=0, overriding stall and all requests.
REQ-030 Reset mid-stall or with pending target SHALL discard the pending target; first post-reset redirect needs a fresh request.

Configuration
REQ-031 Macro PC_SEQUENCER_DELAY_SLOT_EN defined: an accepted request SHALL first advance pc to pc_plus4 (delay slot), then load target on the next non-stalled edge; request during the slot cycle overwrites target.
REQ-032 Macro undefined: target loaded on the first non-stalled edge per REQ-023/026; no delay slot state synthesised.

Verification
REQ-033 rst 2 cycles, then free-run 3 cycles -> pc = 0,4,8,12; redirect=0.
REQ-034 pc=0x100, br_take=1, imm=0xFFFE -> next pc=0x0FC, redirect=1 one cycle (delay slot off).
REQ-035 pc=0x0040_0000, jmp=1 and br_take=1, tgt=0x0000010 -> pc=0x0000_0040, branch ignored.
REQ-036 stall=1, jmp_reg=1 reg_addr=0x2003 then stall 3 more cycles, release -> pc holds, then pc=0x2000, redirect=1, addr_err=1 one cycle after request.
REQ-037 DELAY_SLOT_EN: pc=0x200, jmp_reg reg_addr=0x800 -> pc=0x204 then 0x800; redirect only on 0x800.
REQ-038 pc=0xFFFF_FFFC free-run -> pc=0x0; stall with pending + rst -> pc=RESET_VEC, no later redirect.
